// File: rtl/program_loader.sv
// Program loader: streams a WORDS-byte image into the SAP-1 RAM while holding the CPU in clear,
// then returns the RAM port to the CPU. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | CPU owns RAM port, waiting for load_req
// HOLD    | CPU held in clear, hold timer counting down to settle
// RECV    | byte_ready high, waiting for the next program/checksum byte
// WRITE   | single-cycle RAM write of the latched byte at word_cnt
// CHECK   | compare running sum with checksum byte (checksum build)
// DONE    | image accepted, CPU released and owns RAM port
// ERROR   | checksum mismatch, CPU still held (checksum build)
module program_loader #(
    parameter int WORDS       = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              base_clock,
    input  logic              CLR,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_ce_bar,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we,
    output logic              ram_ce_bar,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_RECV  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        S_CHECK = 3'd5,
        S_ERROR = 3'd6
`endif
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] word_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        byte_reg;
    logic              cpu_owns;
    logic              start;
    logic              last_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       csum_phase;
    assign cpu_owns = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
`else
    assign cpu_owns = (state == S_IDLE) || (state == S_DONE);
`endif

    assign start     = cpu_owns && load_req;
    assign last_word = (word_cnt == ADDR_W'(WORDS - 1));

    always_ff @(posedge base_clock or posedge CLR) begin
        if (CLR) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_req) state_nxt = S_HOLD;
            S_HOLD:  if (hold_cnt == '0) state_nxt = S_RECV;
            S_RECV: begin
                if (byte_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_nxt = csum_phase ? S_CHECK : S_WRITE;
`else
                    state_nxt = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_nxt = S_RECV;
`else
                state_nxt = last_word ? S_DONE : S_RECV;
`endif
            end
            S_DONE:  if (load_req) state_nxt = S_HOLD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: state_nxt = (sum == byte_reg) ? S_DONE : S_ERROR;
            S_ERROR: if (load_req) state_nxt = S_HOLD;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: the terminal compare on word_cnt precedes the increment, so it never wraps.
    always_ff @(posedge base_clock or posedge CLR) begin
        if (CLR) begin
            word_cnt <= '0;
            hold_cnt <= '0;
            byte_reg <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum        <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            if (start) begin
                word_cnt <= '0;
                hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum        <= '0;
                csum_phase <= 1'b0;
`endif
            end
            if (state == S_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            if (state == S_RECV && byte_valid)
                byte_reg <= byte_data;
            if (state == S_WRITE) begin
                if (!last_word)
                    word_cnt <= word_cnt + ADDR_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum <= sum + byte_reg;
                if (last_word)
                    csum_phase <= 1'b1;
`endif
            end
        end
    end

    always_comb begin
        byte_ready = (state == S_RECV);
        ram_we     = (state == S_WRITE);
        ram_data   = byte_reg;
        cpu_hold   = !((state == S_IDLE) || (state == S_DONE));
        load_done  = (state == S_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        load_error = (state == S_ERROR);
`else
        load_error = 1'b0;
`endif
        if (cpu_owns) begin
            ram_addr   = cpu_addr;
            ram_ce_bar = cpu_ce_bar;
        end else begin
            ram_addr   = word_cnt;
            ram_ce_bar = (state != S_WRITE);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver pushes each expected RAM write, a monitor pops on ram_we.
// Checksum scenarios are built only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    localparam int WORDS       = 16;
    localparam int ADDR_W      = 4;
    localparam int HOLD_CYCLES = 4;

    logic              base_clock = 1'b0;
    logic              CLR;
    logic              load_req;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ce_bar;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;
    logic              ram_ce_bar;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  wr_cnt = 0;
    logic prev_we = 1'b0;

    program_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .base_clock (base_clock),
        .CLR        (CLR),
        .load_req   (load_req),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_addr   (cpu_addr),
        .cpu_ce_bar (cpu_ce_bar),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_ce_bar (ram_ce_bar),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial forever #5 base_clock = ~base_clock;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish (compared=%0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial forever begin
        @(negedge base_clock);
        if (ram_we === 1'b1) begin
            wr_cnt++;
            chk("we_single_cycle", 32'(prev_we), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write addr=%0h data=%0h", ram_addr, ram_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.a));
                chk("wr_data", 32'(ram_data), 32'(e.d));
                chk("wr_ce_bar", 32'(ram_ce_bar), 0);
            end
        end
        prev_we = (ram_we === 1'b1);
    end

    task automatic check_reset_outs();
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_cpu_hold", 32'(cpu_hold), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_error", 32'(load_error), 0);
        chk("rst_ram_addr", 32'(ram_addr), 32'(cpu_addr));
        chk("rst_ram_ce_bar", 32'(ram_ce_bar), 32'(cpu_ce_bar));
    endtask

    task automatic arb_check(input logic [ADDR_W-1:0] a, input logic ce);
        cpu_addr   = a;
        cpu_ce_bar = ce;
        #1;
        chk("arb_addr", 32'(ram_addr), 32'(a));
        chk("arb_ce_bar", 32'(ram_ce_bar), 32'(ce));
        chk("arb_we", 32'(ram_we), 0);
    endtask

    task automatic wait_ready();
        int cyc = 0;
        while (byte_ready !== 1'b1 && cyc < 100) begin
            @(negedge base_clock);
            cyc++;
        end
        chk("ready_seen", 32'(byte_ready), 1);
    endtask

    // Called at a negedge; returns at the negedge of the cycle following the accept edge.
    task automatic send_byte(input logic [7:0] d, input bit wr, input logic [ADDR_W-1:0] a);
        byte_valid = 1'b1;
        byte_data  = d;
        wait_ready();
        if (wr) exp_q.push_back('{a: a, d: d});
        @(negedge base_clock);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    // mode 0: random bytes, 1: byte = address, 2: all 0x01
    task automatic do_load(input int mode, input int stall_idx, input int stall_len,
                           input bit hold_req, input bit csum_bad);
        logic [7:0] d;
        logic [7:0] s;
        int cyc;
        s = 8'h00;
        load_req = 1'b1;
        @(negedge base_clock);
        if (!hold_req) load_req = 1'b0;
        chk("hold_rise", 32'(cpu_hold), 1);
        chk("done_cleared", 32'(load_done), 0);
        cyc = 0;
        while (byte_ready !== 1'b1 && cyc < 100) begin
            @(negedge base_clock);
            cyc++;
        end
        chk("first_ready_latency", 32'(cyc), HOLD_CYCLES);
        for (int i = 0; i < WORDS; i++) begin
            d = (mode == 1) ? 8'(i) : (mode == 2) ? 8'h01 : 8'($urandom);
            if (i == stall_idx) begin
                if (i > 0) @(negedge base_clock);
                for (int j = 0; j < stall_len; j++) begin
                    chk("stall_ready", 32'(byte_ready), 1);
                    @(negedge base_clock);
                end
            end
            send_byte(d, 1'b1, ADDR_W'(i));
            s = 8'(s + d);
        end
        load_req = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(csum_bad ? 8'(s + 8'd1) : s, 1'b0, '0);
        chk("check_pending", 32'(load_done), 0);
        @(negedge base_clock);
        chk("end_load_done", 32'(load_done), csum_bad ? 0 : 1);
        chk("end_load_error", 32'(load_error), csum_bad ? 1 : 0);
        chk("end_cpu_hold", 32'(cpu_hold), csum_bad ? 1 : 0);
`else
        chk("done_pending", 32'(load_done), 0);
        @(negedge base_clock);
        chk("end_load_done", 32'(load_done), 1);
        chk("end_load_error", 32'(load_error), 0);
        chk("end_cpu_hold", 32'(cpu_hold), csum_bad ? 1 : 0);
`endif
    endtask

    task automatic abort_test();
        load_req = 1'b1;
        @(negedge base_clock);
        load_req = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1, ADDR_W'(i));
        @(negedge base_clock);
        cpu_addr   = ADDR_W'($urandom);
        cpu_ce_bar = 1'($urandom);
        CLR = 1'b1;
        #1;
        check_reset_outs();
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        repeat (4) @(negedge base_clock);
        CLR = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge base_clock);
            chk("post_abort_ready", 32'(byte_ready), 0);
        end
        byte_valid = 1'b0;
        chk("post_abort_queue", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int snap;
        CLR        = 1'b1;
        load_req   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        cpu_addr   = 4'h3;
        cpu_ce_bar = 1'b1;
        repeat (2) @(negedge base_clock);
        check_reset_outs();
        byte_valid = 1'b1;
        CLR = 1'b0;
        @(negedge base_clock);
        cpu_addr   = 4'hA;
        cpu_ce_bar = 1'b0;
        #1;
        check_reset_outs();
        byte_valid = 1'b0;
        @(negedge base_clock);

        do_load(1, -1, 0, 1'b0, 1'b0);
        arb_check(4'h9, 1'b0);
        for (int k = 0; k < 3; k++) arb_check(ADDR_W'($urandom), 1'($urandom));
        @(negedge base_clock);

        do_load(0, 5, 10, 1'b0, 1'b0);
        @(negedge base_clock);

        abort_test();
        arb_check(ADDR_W'($urandom), 1'($urandom));
        @(negedge base_clock);

        snap = wr_cnt;
        do_load(0, -1, 0, 1'b1, 1'b0);
        @(negedge base_clock);
        chk("held_req_writes", 32'(wr_cnt - snap), WORDS);

        for (int k = 0; k < 4; k++) begin
            do_load(0, $urandom_range(0, WORDS - 1), $urandom_range(0, 6), 1'b0, 1'b0);
            repeat ($urandom_range(1, 3)) @(negedge base_clock);
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_load(2, -1, 0, 1'b0, 1'b0);
        @(negedge base_clock);
        do_load(2, -1, 0, 1'b0, 1'b1);
        arb_check(ADDR_W'($urandom), 1'($urandom));
        @(negedge base_clock);
        do_load(0, 3, 2, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge base_clock);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
